// File: rtl/m_button_filter.sv
// Five-button front end: two-flop synchronizers, per-bit debounce counters,
// and a press-event FSM that emits one directional event per press-release.
module m_button_filter #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic       w_clk,
  input  logic       w_rst,
  input  logic [4:0] fivebuttons,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [2:0] ev_code,
  output logic       ev_multi,
  output logic [4:0] held,
  output logic       idle
);

  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EMIT     = 2'd1,
    S_WAIT_REL = 2'd2
  } state_t;

  logic [4:0]    sync1_q, sync2_q, held_q;
  logic [CW-1:0] cnt_q [5];

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      held_q  <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= fivebuttons;
      sync2_q <= sync1_q;
      // A bit flips only after DEBOUNCE_CYC consecutive mismatching cycles.
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] != held_q[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            held_q[i] <= sync2_q[i];
            cnt_q[i]  <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  // Bit order right, left, down, up, center maps to codes 3, 1, 2, 0, 4.
  logic [2:0] code_of;
  logic       one_hot;
  always_comb begin
    code_of = 3'd0;
    case (held_q)
      5'b00001: code_of = 3'd3;
      5'b00010: code_of = 3'd1;
      5'b00100: code_of = 3'd2;
      5'b01000: code_of = 3'd0;
      5'b10000: code_of = 3'd4;
      default:  code_of = 3'd0;
    endcase
  end
  assign one_hot = $onehot(held_q);

  // Handshake: an event transfers on a rising edge where ev_valid and
  // ev_ready are both 1; ev_code is stable while ev_valid waits for ev_ready.
  state_t     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic       multi_d;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    multi_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (one_hot) begin
          code_d  = code_of;
          state_d = S_EMIT;
        end else if (held_q != 5'd0) begin
          multi_d = 1'b1;
          state_d = S_WAIT_REL;
        end
      end
      S_EMIT:     if (ev_ready) state_d = S_WAIT_REL;
      S_WAIT_REL: if (held_q == 5'd0) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  logic valid_q, multi_q, idle_q;
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q <= S_IDLE;
      code_q  <= 3'd0;
      multi_q <= 1'b0;
      valid_q <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      multi_q <= multi_d;
      valid_q <= (state_d == S_EMIT);
      idle_q  <= (state_d == S_IDLE);
    end
  end

  assign ev_valid = valid_q;
  assign ev_code  = code_q;
  assign ev_multi = multi_q;
  assign held     = held_q;
  assign idle     = idle_q;

endmodule

// File: tb/tb_m_button_filter.sv
// Bench for m_button_filter with a short debounce window; directed scenarios
// followed by random button/ready traffic checked against a behavioural model.
module tb_m_button_filter;

  localparam int DEB = 4;

  logic       w_clk;
  logic       w_rst;
  logic [4:0] fivebuttons;
  logic       ev_valid;
  logic       ev_ready;
  logic [2:0] ev_code;
  logic       ev_multi;
  logic [4:0] held;
  logic       idle;

  m_button_filter #(.DEBOUNCE_CYC(DEB)) dut (
    .w_clk      (w_clk),
    .w_rst      (w_rst),
    .fivebuttons(fivebuttons),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_multi   (ev_multi),
    .held       (held),
    .idle       (idle)
  );

  // clock / reset
  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int         dir_of_bit [5] = '{3, 1, 2, 0, 4};
  logic [4:0] hist [$];
  int         run [5];
  logic [4:0] hm;
  int         pend;
  bit         busy;
  logic       mexp;

  // observation counters
  int         ev_seen, multi_seen, valid_cycles;
  logic       prev_v;
  logic [2:0] rise_code;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist = {5'd0, 5'd0};
    for (int i = 0; i < 5; i++) run[i] = 0;
    hm   = '0;
    pend = -1;
    busy = 1'b0;
    mexp = 1'b0;
  endtask

  task automatic model_edge();
    logic [4:0] seen;
    int n;
    if (w_rst) begin
      model_reset();
    end else begin
      n = $countones(hm);
      mexp = 1'b0;
      if (pend >= 0) begin
        if (ev_ready) begin
          pend = -1;
          busy = 1'b1;
        end
      end else if (busy) begin
        if (hm == 5'd0) busy = 1'b0;
      end else if (n == 1) begin
        for (int i = 0; i < 5; i++) if (hm[i]) pend = dir_of_bit[i];
      end else if (n > 1) begin
        mexp = 1'b1;
        busy = 1'b1;
      end
      // synchronized value seen now is the raw value from two edges back
      seen = hist.pop_front();
      hist.push_back(fivebuttons);
      for (int i = 0; i < 5; i++) begin
        if (seen[i] != hm[i]) begin
          run[i]++;
          if (run[i] == DEB) begin
            hm[i]  = seen[i];
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge w_clk);
    model_edge();
    #1;
    chk("held", 32'(held), 32'(hm));
    chk("ev_valid", 32'(ev_valid), 32'(pend >= 0));
    chk("ev_multi", 32'(ev_multi), 32'(mexp));
    chk("idle", 32'(idle), 32'(!busy && pend < 0));
    if (pend >= 0) chk("ev_code", 32'(ev_code), 32'(pend));
    if (ev_valid && !prev_v) begin
      ev_seen++;
      rise_code = ev_code;
    end
    if (ev_valid) valid_cycles++;
    if (ev_multi) multi_seen++;
    prev_v = ev_valid;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int k;
    k = 0;
    while (!ev_valid && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(ev_valid), 32'd1);
  endtask

  initial begin
    int t_held, t_valid, t_idle, e0, v0, m0, seg;
    logic held_any;

    model_reset();
    ev_seen = 0; multi_seen = 0; valid_cycles = 0; prev_v = 1'b0; rise_code = '0;
    w_rst = 1'b1;
    fivebuttons = '0;
    ev_ready = 1'b0;
    steps(3);
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_code", 32'(ev_code), 32'd0);
    chk("rst_multi", 32'(ev_multi), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_held", 32'(held), 32'd0);
    w_rst = 1'b0;
    steps(2);

    // clean press of up
    e0 = ev_seen; v0 = valid_cycles;
    t_held = -1; t_valid = -1;
    ev_ready = 1'b1;
    fivebuttons = 5'b01000;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (held == 5'b01000 && t_held < 0) t_held = k;
      if (ev_valid && t_valid < 0) t_valid = k;
    end
    chk("press_held_edge", 32'(t_held), 32'd6);
    chk("press_valid_edge", 32'(t_valid), 32'd7);
    chk("press_events", 32'(ev_seen - e0), 32'd1);
    chk("press_valid_cycles", 32'(valid_cycles - v0), 32'd1);
    chk("press_code", 32'(rise_code), 32'd0);
    fivebuttons = '0;
    t_idle = -1;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (idle && t_idle < 0) t_idle = k;
    end
    chk("release_idle_edge", 32'(t_idle), 32'd7);

    // backpressure on right, released while waiting
    e0 = ev_seen; v0 = valid_cycles;
    ev_ready = 1'b0;
    fivebuttons = 5'b00001;
    wait_valid(30, "bp_valid_timeout");
    for (int j = 1; j <= 10; j++) begin
      step();
      if (j == 5) fivebuttons = '0;
    end
    ev_ready = 1'b1;
    steps(20);
    chk("bp_valid_cycles", 32'(valid_cycles - v0), 32'd11);
    chk("bp_events", 32'(ev_seen - e0), 32'd1);
    chk("bp_code", 32'(rise_code), 32'd3);
    chk("bp_idle", 32'(idle), 32'd1);

    // glitch on center
    e0 = ev_seen;
    held_any = 1'b0;
    fivebuttons = 5'b10000;
    for (int k = 0; k < 3; k++) begin step(); held_any |= (held != 0); end
    fivebuttons = '0;
    for (int k = 0; k < 20; k++) begin step(); held_any |= (held != 0); end
    chk("glitch_held", 32'(held_any), 32'd0);
    chk("glitch_events", 32'(ev_seen - e0), 32'd0);

    // left+down together, then single left
    e0 = ev_seen; m0 = multi_seen;
    fivebuttons = 5'b00110;
    steps(20);
    fivebuttons = '0;
    steps(15);
    chk("multi_pulses", 32'(multi_seen - m0), 32'd1);
    chk("multi_events", 32'(ev_seen - e0), 32'd0);
    fivebuttons = 5'b00010;
    steps(20);
    fivebuttons = '0;
    steps(15);
    chk("left_events", 32'(ev_seen - e0), 32'd1);
    chk("left_code", 32'(rise_code), 32'd1);

    // down held for a long time
    e0 = ev_seen;
    fivebuttons = 5'b00100;
    steps(100);
    fivebuttons = '0;
    steps(15);
    chk("hold_events", 32'(ev_seen - e0), 32'd1);
    chk("hold_code", 32'(rise_code), 32'd2);

    // reset while an event is pending
    ev_ready = 1'b0;
    fivebuttons = 5'b01000;
    wait_valid(30, "emit_valid_timeout");
    w_rst = 1'b1;
    step();
    chk("emit_rst_valid", 32'(ev_valid), 32'd0);
    chk("emit_rst_idle", 32'(idle), 32'd1);
    chk("emit_rst_held", 32'(held), 32'd0);
    w_rst = 1'b0;
    ev_ready = 1'b1;
    t_valid = -1;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (ev_valid && t_valid < 0) t_valid = k;
    end
    chk("after_rst_valid_edge", 32'(t_valid), 32'd7);
    chk("after_rst_code", 32'(rise_code), 32'd0);
    fivebuttons = '0;
    steps(15);

    // random traffic
    for (seg = 0; seg < 60; seg++) begin
      fivebuttons = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      for (int k = 0; k < int'($urandom_range(1, 14)); k++) begin
        ev_ready = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 150) == 0) w_rst = 1'b1;
        step();
        w_rst = 1'b0;
      end
    end
    fivebuttons = '0;
    ev_ready = 1'b1;
    steps(20);
    chk("final_idle", 32'(idle), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
